// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MIPS32 memory-access stage:
//     - opcode constants for the memory and branch instructions
//     - state encoding of the memory-stage handshake FSM
//     - helpers that classify an opcode
//   No ports; imported by mem_stage and ex_mem_latch.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0] OP_LD   = 6'b101000;
    localparam logic [5:0] OP_ST   = 6'b101001;
    localparam logic [5:0] OP_BEQZ = 6'b110100;
    localparam logic [5:0] OP_BNEZ = 6'b110101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // True for the two opcodes that touch data memory.
    function automatic logic is_mem_op(input logic [5:0] opcode);
        return (opcode == OP_LD) || (opcode == OP_ST);
    endfunction

    function automatic logic is_load_op(input logic [5:0] opcode);
        return (opcode == OP_LD);
    endfunction

    function automatic logic is_store_op(input logic [5:0] opcode);
        return (opcode == OP_ST);
    endfunction

endpackage

// File: rtl/mem_stage_ex_mem_latch.sv
// -----------------------------------------------------------------------------
// ex_mem_latch
//   EX/MEM pipeline register. Loads the execute-stage results when en_i is
//   high and holds them otherwise. Synchronous active-low reset clears all
//   fields to zero.
//   Ports:
//     clk, rst_n     clock / synchronous active-low reset
//     en_i           load enable (instruction accepted this cycle)
//     ir_i, alu_i, b_i, npc_i, sel_i   execute-stage values
//     ir_o, alu_o, b_o, npc_o, sel_o   registered copies
// -----------------------------------------------------------------------------
module ex_mem_latch
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [31:0] ir_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] b_i,
    input  logic [31:0] npc_i,
    input  logic        sel_i,
    output logic [31:0] ir_o,
    output logic [31:0] alu_o,
    output logic [31:0] b_o,
    output logic [31:0] npc_o,
    output logic        sel_o
);

    logic [31:0] ir_q,  ir_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] b_q,   b_d;
    logic [31:0] npc_q, npc_d;
    logic        sel_q, sel_d;

    // Next-state: load new values on enable, otherwise hold.
    always_comb begin
        ir_d  = ir_q;
        alu_d = alu_q;
        b_d   = b_q;
        npc_d = npc_q;
        sel_d = sel_q;
        if (en_i) begin
            ir_d  = ir_i;
            alu_d = alu_i;
            b_d   = b_i;
            npc_d = npc_i;
            sel_d = sel_i;
        end else begin
            ir_d  = ir_q;
            alu_d = alu_q;
            b_d   = b_q;
            npc_d = npc_q;
            sel_d = sel_q;
        end
    end

    // Capture register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_q  <= 32'h0000_0000;
            alu_q <= 32'h0000_0000;
            b_q   <= 32'h0000_0000;
            npc_q <= 32'h0000_0000;
            sel_q <= 1'b0;
        end else begin
            ir_q  <= ir_d;
            alu_q <= alu_d;
            b_q   <= b_d;
            npc_q <= npc_d;
            sel_q <= sel_d;
        end
    end

    assign ir_o  = ir_q;
    assign alu_o = alu_q;
    assign b_o   = b_q;
    assign npc_o = npc_q;
    assign sel_o = sel_q;

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of the 5-stage MIPS32 pipeline. Captures execute
//   results into the EX/MEM register, runs word loads/stores through a
//   variable-latency req/ack data-memory handshake and emits a one-cycle
//   mem_valid pulse to write-back.
//   Ports:
//     clk, rst_n                    clock / synchronous active-low reset
//     ex_valid, ex_ready            execute-stage handshake
//     IR_ex, ALU_res, B_ex, NPC_ex, sel   execute-stage results
//     dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_ack, dmem_rdata
//                                   data-memory interface (word addressed)
//     mem_valid, IR_mem, ALU_mem, LMD, NPC_mem, sel_mem, mem_err
//                                   results to write-back
// -----------------------------------------------------------------------------
module mem_stage
    import mips_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [31:0]   IR_ex,
    input  logic [31:0]   ALU_res,
    input  logic [31:0]   B_ex,
    input  logic [31:0]   NPC_ex,
    input  logic          sel,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_ack,
    input  logic [31:0]   dmem_rdata,
    output logic          mem_valid,
    output logic [31:0]   IR_mem,
    output logic [31:0]   ALU_mem,
    output logic [31:0]   LMD,
    output logic [31:0]   NPC_mem,
    output logic          sel_mem,
    output logic          mem_err
);

    mem_state_e  state_q, state_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mem_err_q, mem_err_d;
    logic [31:0] lmd_q, lmd_d;

    logic        accept_s;
    logic        ex_is_mem_s;
    logic        addr_bad_s;
    logic [31:0] b_mem_s;

    // Byte address must be word aligned and fit inside the AW-bit word space.
    function automatic logic addr_illegal(input logic [31:0] byte_addr);
        return (byte_addr[1:0] != 2'b00) || (byte_addr[31:AW+2] != '0);
    endfunction

    assign accept_s    = ex_valid && ex_ready;
    assign ex_is_mem_s = is_mem_op(IR_ex[31:26]);
    assign addr_bad_s  = addr_illegal(ALU_res);

    ex_mem_latch u_latch (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (accept_s),
        .ir_i  (IR_ex),
        .alu_i (ALU_res),
        .b_i   (B_ex),
        .npc_i (NPC_ex),
        .sel_i (sel),
        .ir_o  (IR_mem),
        .alu_o (ALU_mem),
        .b_o   (b_mem_s),
        .npc_o (NPC_mem),
        .sel_o (sel_mem)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: only a legal LD/ST enters WAIT; ack is ignored in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && ex_is_mem_s && !addr_bad_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: pure functions of state, so no ack-to-ready path exists.
    always_comb begin
        ex_ready = 1'b1;
        dmem_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ex_ready = 1'b1;
                dmem_req = 1'b0;
            end
            ST_WAIT: begin
                ex_ready = 1'b0;
                dmem_req = 1'b1;
            end
            default: begin
                ex_ready = 1'b1;
                dmem_req = 1'b0;
            end
        endcase
    end

    // Result pulse, error flag and load data for the next cycle.
    always_comb begin
        mem_valid_d = 1'b0;
        mem_err_d   = 1'b0;
        lmd_d       = lmd_q;
        if (state_q == ST_WAIT) begin
            if (dmem_ack) begin
                mem_valid_d = 1'b1;
                if (is_load_op(IR_mem[31:26])) begin
                    lmd_d = dmem_rdata;
                end else begin
                    lmd_d = lmd_q;
                end
            end else begin
                mem_valid_d = 1'b0;
            end
        end else begin
            // IDLE: non-memory ops and rejected LD/ST complete in one cycle.
            if (accept_s && (!ex_is_mem_s || addr_bad_s)) begin
                mem_valid_d = 1'b1;
                mem_err_d   = ex_is_mem_s;
            end else begin
                mem_valid_d = 1'b0;
                mem_err_d   = 1'b0;
            end
        end
    end

    // Result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_valid_q <= 1'b0;
            mem_err_q   <= 1'b0;
            lmd_q       <= 32'h0000_0000;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_err_q   <= mem_err_d;
            lmd_q       <= lmd_d;
        end
    end

    // Memory-side fields come straight from the EX/MEM register, which is
    // frozen while in WAIT, so they are stable for the whole request.
    assign dmem_addr  = ALU_mem[AW+1:2];
    assign dmem_wdata = b_mem_s;
    assign dmem_we    = is_store_op(IR_mem[31:26]);

    assign mem_valid  = mem_valid_q;
    assign mem_err    = mem_err_q;
    assign LMD        = lmd_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int AW = 10;

    localparam logic [31:0] I_ADD  = 32'h0000_0020;
    localparam logic [31:0] I_LD   = 32'hA000_0000;
    localparam logic [31:0] I_ST   = 32'hA400_0000;
    localparam logic [31:0] I_BEQZ = 32'hD000_0000;

    logic          clk;
    logic          rst_n;
    logic          ex_valid;
    logic          ex_ready;
    logic [31:0]   IR_ex, ALU_res, B_ex, NPC_ex;
    logic          sel;
    logic          dmem_req, dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic          dmem_ack;
    logic [31:0]   dmem_rdata;
    logic          mem_valid;
    logic [31:0]   IR_mem, ALU_mem, LMD, NPC_mem;
    logic          sel_mem, mem_err;

    int n_vec = 0;
    int n_err = 0;

    mem_stage #(.AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .IR_ex      (IR_ex),
        .ALU_res    (ALU_res),
        .B_ex       (B_ex),
        .NPC_ex     (NPC_ex),
        .sel        (sel),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .mem_valid  (mem_valid),
        .IR_mem     (IR_mem),
        .ALU_mem    (ALU_mem),
        .LMD        (LMD),
        .NPC_mem    (NPC_mem),
        .sel_mem    (sel_mem),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_mem_valid"}, {31'd0, mem_valid}, 32'd0);
        chk({pfx, "_dmem_req"},  {31'd0, dmem_req},  32'd0);
        chk({pfx, "_dmem_we"},   {31'd0, dmem_we},   32'd0);
        chk({pfx, "_mem_err"},   {31'd0, mem_err},   32'd0);
        chk({pfx, "_sel_mem"},   {31'd0, sel_mem},   32'd0);
        chk({pfx, "_IR_mem"},    IR_mem,             32'd0);
        chk({pfx, "_ALU_mem"},   ALU_mem,            32'd0);
        chk({pfx, "_LMD"},       LMD,                32'd0);
        chk({pfx, "_NPC_mem"},   NPC_mem,            32'd0);
        chk({pfx, "_dmem_addr"}, {22'd0, dmem_addr}, 32'd0);
        chk({pfx, "_dmem_wdata"}, dmem_wdata,        32'd0);
        chk({pfx, "_ex_ready"},  {31'd0, ex_ready},  32'd1);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; IR_ex = 32'd0; ALU_res = 32'd0;
        B_ex = 32'd0; NPC_ex = 32'd0; sel = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        tick(); tick();
        rst_n = 1'b1;
        chk_reset_state("rst");

        // ADD passes through in one cycle
        ex_valid = 1'b1; IR_ex = I_ADD; ALU_res = 32'h5;
        chk("add_ready", {31'd0, ex_ready}, 32'd1);
        tick();
        ex_valid = 1'b0;
        chk("add_valid", {31'd0, mem_valid}, 32'd1);
        chk("add_alu",   ALU_mem, 32'd5);
        chk("add_req",   {31'd0, dmem_req}, 32'd0);
        chk("add_rdy2",  {31'd0, ex_ready}, 32'd1);
        chk("add_err",   {31'd0, mem_err}, 32'd0);
        tick();
        chk("add_pulse", {31'd0, mem_valid}, 32'd0);

        // ST, ack in third request cycle
        ex_valid = 1'b1; IR_ex = I_ST; ALU_res = 32'h10; B_ex = 32'hDEAD_BEEF;
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("st_req",   {31'd0, dmem_req}, 32'd1);
            chk("st_we",    {31'd0, dmem_we},  32'd1);
            chk("st_addr",  {22'd0, dmem_addr}, 32'd4);
            chk("st_wdata", dmem_wdata, 32'hDEAD_BEEF);
            chk("st_ready", {31'd0, ex_ready}, 32'd0);
            chk("st_novld", {31'd0, mem_valid}, 32'd0);
            if (i == 2) dmem_ack = 1'b1;
            tick();
        end
        dmem_ack = 1'b0;
        chk("st_valid", {31'd0, mem_valid}, 32'd1);
        chk("st_req_off", {31'd0, dmem_req}, 32'd0);
        chk("st_ready_back", {31'd0, ex_ready}, 32'd1);
        chk("st_lmd", LMD, 32'd0);
        chk("st_err", {31'd0, mem_err}, 32'd0);
        tick();
        chk("st_pulse", {31'd0, mem_valid}, 32'd0);

        // LD with ack in first request cycle
        ex_valid = 1'b1; IR_ex = I_LD; ALU_res = 32'h10; B_ex = 32'd0;
        tick();
        ex_valid = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        chk("ld_req", {31'd0, dmem_req}, 32'd1);
        chk("ld_we",  {31'd0, dmem_we},  32'd0);
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        chk("ld_valid", {31'd0, mem_valid}, 32'd1);
        chk("ld_lmd", LMD, 32'h1234_5678);
        chk("ld_ready", {31'd0, ex_ready}, 32'd1);

        // Misaligned LD, then out-of-range LD back to back
        ex_valid = 1'b1; IR_ex = I_LD; ALU_res = 32'h12;
        tick();
        chk("mis_valid", {31'd0, mem_valid}, 32'd1);
        chk("mis_err",   {31'd0, mem_err},   32'd1);
        chk("mis_req",   {31'd0, dmem_req},  32'd0);
        chk("mis_ready", {31'd0, ex_ready},  32'd1);
        chk("mis_lmd",   LMD, 32'h1234_5678);
        ALU_res = 32'h1000;
        tick();
        ex_valid = 1'b0;
        chk("oor_valid", {31'd0, mem_valid}, 32'd1);
        chk("oor_err",   {31'd0, mem_err},   32'd1);
        chk("oor_req",   {31'd0, dmem_req},  32'd0);
        tick();
        chk("oor_pulse", {31'd0, mem_valid}, 32'd0);
        chk("oor_errclr", {31'd0, mem_err}, 32'd0);
        chk("oor_req2",  {31'd0, dmem_req},  32'd0);

        // Stream: ADD, LD (ack in 2nd request cycle), BEQZ
        ex_valid = 1'b1; IR_ex = I_ADD; ALU_res = 32'h7; sel = 1'b0; NPC_ex = 32'd0;
        tick();
        chk("s_add_valid", {31'd0, mem_valid}, 32'd1);
        chk("s_add_ir", IR_mem, I_ADD);
        chk("s_rdy1", {31'd0, ex_ready}, 32'd1);
        IR_ex = I_LD; ALU_res = 32'h20;
        tick();
        chk("s_ld_wait_rdy", {31'd0, ex_ready}, 32'd0);
        chk("s_ld_novld", {31'd0, mem_valid}, 32'd0);
        chk("s_ld_addr", {22'd0, dmem_addr}, 32'd8);
        IR_ex = I_BEQZ; ALU_res = 32'h0; sel = 1'b1; NPC_ex = 32'h40;
        tick();
        chk("s_ld_wait2_rdy", {31'd0, ex_ready}, 32'd0);
        chk("s_ld_ir_held", IR_mem, I_LD);
        chk("s_ld_req", {31'd0, dmem_req}, 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        chk("s_ld_valid", {31'd0, mem_valid}, 32'd1);
        chk("s_ld_ir", IR_mem, I_LD);
        chk("s_ld_lmd", LMD, 32'hCAFE_F00D);
        chk("s_rdy2", {31'd0, ex_ready}, 32'd1);
        tick();
        ex_valid = 1'b0; sel = 1'b0; NPC_ex = 32'd0;
        chk("s_br_valid", {31'd0, mem_valid}, 32'd1);
        chk("s_br_ir", IR_mem, I_BEQZ);
        chk("s_br_sel", {31'd0, sel_mem}, 32'd1);
        chk("s_br_npc", NPC_mem, 32'h40);
        chk("s_br_lmd", LMD, 32'hCAFE_F00D);
        tick();
        chk("s_end", {31'd0, mem_valid}, 32'd0);

        // Reset in the 2nd WAIT cycle, then stray ack
        ex_valid = 1'b1; IR_ex = I_LD; ALU_res = 32'h10;
        tick();
        ex_valid = 1'b0;
        chk("r_wait1", {31'd0, dmem_req}, 32'd1);
        tick();
        chk("r_wait2", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_state("r_rst");
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        chk("r_ack_novld", {31'd0, mem_valid}, 32'd0);
        chk("r_ack_req", {31'd0, dmem_req}, 32'd0);
        chk("r_ack_lmd", LMD, 32'd0);
        chk("r_ack_rdy", {31'd0, ex_ready}, 32'd1);
        tick();
        chk("r_end", {31'd0, mem_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
